// File: rtl/quad_regfile.sv
// Four-entry register file with one synchronous write port and two
// combinational read ports, each read port built from a quadmux.
// A same-cycle read of the register being written can optionally be
// forwarded straight from the write data.

// Four-input, one-output selector: sel 0..3 picks a, b, c, d.
module quadmux #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y
);

   // Pure combinational pick of one of the four inputs.
   always_comb begin
      y = a;
      unique case (sel)
         2'd0: y = a;
         2'd1: y = b;
         2'd2: y = c;
         2'd3: y = d;
         default: y = a;
      endcase
   end

endmodule

module quad_regfile #(
   parameter int WIDTH     = 8,
   parameter int BYPASS    = 1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [1:0]       raddr_a,
   input  logic [1:0]       raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b,
   output logic [3:0]       dirty
);

   // Reset value cut down to the register width.
   localparam logic [WIDTH-1:0] RESET_WORD = WIDTH'(RESET_VAL);
   localparam bit               USE_BYPASS = (BYPASS != 0);

   logic [WIDTH-1:0] regs_q [4];
   logic [WIDTH-1:0] regs_d [4];
   logic [3:0]       dirty_q;
   logic [3:0]       dirty_d;

   logic [WIDTH-1:0] stored_a;
   logic [WIDTH-1:0] stored_b;
   logic             fwd_a;
   logic             fwd_b;

   // Next-state for storage and dirty flags: only the addressed entry changes on a write.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      dirty_d = dirty_q;
      if (we) begin
         regs_d[waddr]  = wdata;
         dirty_d[waddr] = 1'b1;
      end
   end

   // State registers; reset wins over any write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= RESET_WORD;
         end
         dirty_q <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         dirty_q <= dirty_d;
      end
   end

   quadmux #(.WIDTH(WIDTH)) u_mux_a (
      .a   (regs_q[0]),
      .b   (regs_q[1]),
      .c   (regs_q[2]),
      .d   (regs_q[3]),
      .sel (raddr_a),
      .y   (stored_a)
   );

   quadmux #(.WIDTH(WIDTH)) u_mux_b (
      .a   (regs_q[0]),
      .b   (regs_q[1]),
      .c   (regs_q[2]),
      .d   (regs_q[3]),
      .sel (raddr_b),
      .y   (stored_b)
   );

   // Forwarding decision per port; a reset cycle never forwards because the write is dropped.
   always_comb begin
      fwd_a = USE_BYPASS && we && !rst && (raddr_a == waddr);
      fwd_b = USE_BYPASS && we && !rst && (raddr_b == waddr);
   end

   // Final read data: forwarded write data or the stored register.
   always_comb begin
      rdata_a = fwd_a ? wdata : stored_a;
      rdata_b = fwd_b ? wdata : stored_b;
   end

   assign dirty = dirty_q;

endmodule

// File: tb/tb_quad_regfile.sv
// Scoreboard bench for quad_regfile: one forwarding and one non-forwarding
// instance share the same stimulus and are checked against an array model.
module tb_quad_regfile;

   logic       clk;
   logic       rst;
   logic       we;
   logic [1:0] waddr;
   logic [7:0] wdata;
   logic [1:0] raddr_a;
   logic [1:0] raddr_b;
   logic [7:0] rdata_a_byp, rdata_b_byp, rdata_a_nob, rdata_b_nob;
   logic [3:0] dirty_byp, dirty_nob;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic [7:0] a_byp;
      logic [7:0] b_byp;
      logic [7:0] a_nob;
      logic [7:0] b_nob;
      logic [3:0] dirty;
   } exp_t;

   exp_t sb[$];

   logic [7:0] model_mem [4];
   logic [3:0] model_dirty;
   bit         model_valid = 0;

   quad_regfile #(.WIDTH(8), .BYPASS(1), .RESET_VAL(0)) dut_byp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rdata_a_byp), .rdata_b(rdata_b_byp), .dirty(dirty_byp)
   );

   quad_regfile #(.WIDTH(8), .BYPASS(0), .RESET_VAL(0)) dut_nob (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rdata_a_nob), .rdata_b(rdata_b_nob), .dirty(dirty_nob)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Drive one cycle, queue the reads the model predicts for it, then step the model past the edge.
   task automatic apply_stimulus(input string name, input logic r, input logic w,
                                 input logic [1:0] wa, input logic [7:0] wd,
                                 input logic [1:0] ra, input logic [1:0] rb);
      exp_t e;
      rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
      if (model_valid) begin
         e.name  = name;
         e.a_nob = model_mem[ra];
         e.b_nob = model_mem[rb];
         e.a_byp = (w && !r && ra == wa) ? wd : model_mem[ra];
         e.b_byp = (w && !r && rb == wa) ? wd : model_mem[rb];
         e.dirty = model_dirty;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
         model_dirty = 4'b0000;
         model_valid = 1;
      end else if (w) begin
         model_mem[wa]     = wd;
         model_dirty[wa]   = 1'b1;
      end
   endtask

   task automatic check_output(input string name, input string field,
                               input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s.%s: got %h expected %h", name, field, actual, expected);
      end
   endtask

   // Monitor: mid-cycle, pop the prediction for this cycle and compare all outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output(e.name, "rdata_a_byp", rdata_a_byp, e.a_byp);
            check_output(e.name, "rdata_b_byp", rdata_b_byp, e.b_byp);
            check_output(e.name, "rdata_a_nob", rdata_a_nob, e.a_nob);
            check_output(e.name, "rdata_b_nob", rdata_b_nob, e.b_nob);
            check_output(e.name, "dirty_byp", {4'h0, dirty_byp}, {4'h0, e.dirty});
            check_output(e.name, "dirty_nob", {4'h0, dirty_nob}, {4'h0, e.dirty});
         end
      end
   end

   initial begin
      rst = 1; we = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
      @(posedge clk);
      #1;

      // Reset with a write pending: the write must be discarded.
      apply_stimulus("reset", 1, 1, 2'd2, 8'hAA, 2'd0, 2'd0);
      for (int i = 0; i < 4; i++)
         apply_stimulus("reset_sweep", 0, 0, 2'd0, 8'h00, 2'(i), 2'(3 - i));

      // Fill all four registers, then sweep both ports in opposite order.
      for (int i = 0; i < 4; i++)
         apply_stimulus("write_all", 0, 1, 2'(i), 8'(8'h11 * (i + 1)), 2'(i), 2'(3 - i));
      for (int i = 0; i < 4; i++)
         apply_stimulus("read_all", 0, 0, 2'd0, 8'h00, 2'(i), 2'(3 - i));

      // Same-cycle read of the register being written, then the settled value.
      apply_stimulus("bypass", 0, 1, 2'd1, 8'h5A, 2'd1, 2'd1);
      apply_stimulus("after_bypass", 0, 0, 2'd0, 8'h00, 2'd1, 2'd0);

      // Write enable low must leave r0 and dirty alone.
      for (int i = 0; i < 3; i++)
         apply_stimulus("write_disabled", 0, 0, 2'd0, 8'hFF, 2'd0, 2'd0);

      // Reset in the middle of activity, then a fresh write.
      apply_stimulus("mid_reset", 1, 1, 2'd3, 8'h99, 2'd3, 2'd3);
      for (int i = 0; i < 4; i++)
         apply_stimulus("mid_reset_sweep", 0, 0, 2'd0, 8'h00, 2'(i), 2'(i));
      apply_stimulus("post_reset_write", 0, 1, 2'd3, 8'h77, 2'd0, 2'd3);
      apply_stimulus("post_reset_read", 0, 0, 2'd0, 8'h00, 2'd0, 2'd3);

      // Random traffic with occasional resets.
      for (int n = 0; n < 1000; n++)
         apply_stimulus("random", ($urandom_range(0, 49) == 0), 1'($urandom),
                        2'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));

      rst = 0; we = 0;
      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
